// File: rtl/fft_stage_sequencer.sv
// Control FSM for the in-place radix-2 FFT: load, log2(N) butterfly stages, unload.
// Drives AGU stage/pair counters, ping-pong bank select and a latency-aligned write strobe.
module fft_stage_sequencer #(
   parameter int unsigned N           = 32,
   parameter int unsigned PipeLatency = 3,
   parameter int unsigned CountWidth  = 16,
   localparam int unsigned Log2N       = $clog2(N),
   localparam int unsigned StageWidth  = $clog2(Log2N),
   localparam int unsigned PairIdWidth = Log2N - 1,
   localparam int unsigned DrainWidth  = (PipeLatency > 1) ? $clog2(PipeLatency) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   inverse_i,
   input  logic                   abort_i,
   input  logic                   in_done_i,
   input  logic                   out_done_i,
   output logic                   busy_o,
   output logic                   input_en_o,
   output logic                   output_en_o,
   output logic [StageWidth-1:0]  stage_o,
   output logic [PairIdWidth-1:0] pair_id_o,
   output logic                   rd_en_o,
   output logic                   wr_en_o,
   output logic                   bank_select_o,
   output logic                   inverse_mode_o,
   output logic                   done_o,
   output logic [CountWidth-1:0]  frame_count_o
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCompute,
      StDrain,
      StUnload,
      StDone
   } state_e;

   state_e                 state_q;
   logic                   busy_q;
   logic                   input_en_q;
   logic                   output_en_q;
   logic                   rd_en_q;
   logic                   bank_q;
   logic                   inverse_q;
   logic                   done_q;
   logic [StageWidth-1:0]  stage_q;
   logic [PairIdWidth-1:0] pair_q;
   logic [DrainWidth-1:0]  drain_q;
   logic [CountWidth-1:0]  frame_count_q;
   logic [PipeLatency-1:0] wr_pipe_q;

   logic abort_hit;
   assign abort_hit = abort_i && (state_q != StIdle);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         busy_q        <= 1'b0;
         input_en_q    <= 1'b0;
         output_en_q   <= 1'b0;
         rd_en_q       <= 1'b0;
         bank_q        <= 1'b0;
         inverse_q     <= 1'b0;
         done_q        <= 1'b0;
         stage_q       <= '0;
         pair_q        <= '0;
         drain_q       <= '0;
         frame_count_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort_hit) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            input_en_q  <= 1'b0;
            output_en_q <= 1'b0;
            rd_en_q     <= 1'b0;
            stage_q     <= '0;
            pair_q      <= '0;
            drain_q     <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start_i) begin
                     state_q    <= StLoad;
                     busy_q     <= 1'b1;
                     input_en_q <= 1'b1;
                     inverse_q  <= inverse_i;
                     bank_q     <= 1'b0;
                     stage_q    <= '0;
                     pair_q     <= '0;
                  end
               end
               StLoad: begin
                  if (in_done_i) begin
                     state_q    <= StCompute;
                     input_en_q <= 1'b0;
                     rd_en_q    <= 1'b1;
                     bank_q     <= 1'b1;
                  end
               end
               StCompute: begin
                  if (pair_q == PairIdWidth'(N / 2 - 1)) begin
                     state_q <= StDrain;
                     rd_en_q <= 1'b0;
                     pair_q  <= '0;
                     drain_q <= '0;
                  end else begin
                     pair_q <= pair_q + 1'b1;
                  end
               end
               StDrain: begin
                  // Wait out the BPU pipeline so the next stage never reads stale data.
                  if (drain_q == DrainWidth'(PipeLatency - 1)) begin
                     bank_q <= ~bank_q;
                     if (stage_q == StageWidth'(Log2N - 1)) begin
                        state_q     <= StUnload;
                        output_en_q <= 1'b1;
                     end else begin
                        state_q <= StCompute;
                        stage_q <= stage_q + 1'b1;
                        rd_en_q <= 1'b1;
                     end
                  end else begin
                     drain_q <= drain_q + 1'b1;
                  end
               end
               StUnload: begin
                  if (out_done_i) begin
                     state_q       <= StDone;
                     output_en_q   <= 1'b0;
                     done_q        <= 1'b1;
                     frame_count_q <= frame_count_q + 1'b1;
                  end
               end
               StDone: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  stage_q <= '0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Bit 0 takes rd_en; wr_en is the oldest bit, exactly PipeLatency cycles later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_pipe_q <= '0;
      end else if (abort_hit) begin
         wr_pipe_q <= '0;
      end else begin
         wr_pipe_q <= (wr_pipe_q << 1) | PipeLatency'(rd_en_q);
      end
   end

   assign busy_o         = busy_q;
   assign input_en_o     = input_en_q;
   assign output_en_o    = output_en_q;
   assign stage_o        = stage_q;
   assign pair_id_o      = pair_q;
   assign rd_en_o        = rd_en_q;
   assign wr_en_o        = wr_pipe_q[PipeLatency-1];
   assign bank_select_o  = bank_q;
   assign inverse_mode_o = inverse_q;
   assign done_o         = done_q;
   assign frame_count_o  = frame_count_q;

endmodule
